// File: rtl/mem_access.sv
// mem_access: MEM-stage data-bus access unit.
// Runs one load or store per instruction over a request/ack data bus,
// holds the pipeline until the access completes or times out, and
// formats load data (byte/half/word, sign or zero extension).
// Optional build macro MEM_ALIGN_CHECK_EN: when defined, misaligned
// half/word accesses raise adel/ades and never reach the bus; when
// undefined, the low address bits are ignored for half/word accesses.
module mem_access #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata_in,
  output logic        dreq,
  output logic        dwe,
  output logic [3:0]  dbe,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  input  logic [31:0] drdata,
  input  logic        dack,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        adel,
  output logic        ades,
  output logic        bus_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Last BUSY count value before the access is declared dead.
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [9:0]  busy_cnt;
  logic        req_any;
  logic        is_byte;
  logic        is_half;
  logic        addr_err;
  logic        start;
  logic [1:0]  off_p0;
  logic [3:0]  be_p0;
  logic [31:0] wd_p0;

  // Request held for the duration of the access (used to format the load).
  logic        load_p1;
  logic [1:0]  size_p1;
  logic        sign_p1;
  logic [1:0]  off_p1;

  // Select the addressed byte/half of the bus word and extend it.
  function automatic logic [31:0] fmt_load(input logic [31:0] rd,
                                           input logic [1:0]  sz,
                                           input logic        sx,
                                           input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (sz)
      2'b00:   fmt_load = {{24{sx & b[7]}}, b};
      2'b01:   fmt_load = {{16{sx & h[15]}}, h};
      default: fmt_load = rd;
    endcase
  endfunction

  assign req_any = in_valid & (mem_read | mem_write);
  assign is_byte = (mem_size == 2'b00);
  assign is_half = (mem_size == 2'b01);

`ifdef MEM_ALIGN_CHECK_EN
  assign addr_err = (is_half & addr[0]) | (mem_size[1] & (addr[1:0] != 2'b00));
  assign adel     = in_valid & mem_read & addr_err;
  assign ades     = in_valid & ~mem_read & mem_write & addr_err;
`else
  assign addr_err = 1'b0;
  assign adel     = 1'b0;
  assign ades     = 1'b0;
`endif

  assign start = req_any & ~addr_err;
  assign stall = ((state == IDLE) & start) | (state == BUSY);

  // Lane offset, byte enables and lane-placed store data for the new request.
  always_comb begin
    off_p0 = 2'b00;
    be_p0  = 4'b1111;
    wd_p0  = wdata_in;
    if (is_byte) begin
      off_p0 = addr[1:0];
      be_p0  = 4'b0001 << addr[1:0];
      wd_p0  = {4{wdata_in[7:0]}};
    end else if (is_half) begin
      off_p0 = {addr[1], 1'b0};
      be_p0  = addr[1] ? 4'b1100 : 4'b0011;
      wd_p0  = {2{wdata_in[15:0]}};
    end
  end

  // Access FSM: bus request registers, timeout counter and load result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy_cnt  <= '0;
      dreq      <= 1'b0;
      dwe       <= 1'b0;
      dbe       <= 4'b0000;
      daddr     <= '0;
      dwdata    <= '0;
      load_data <= '0;
      bus_err   <= 1'b0;
      load_p1   <= 1'b0;
      size_p1   <= 2'b00;
      sign_p1   <= 1'b0;
      off_p1    <= 2'b00;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          // p0 -> p1: capture the request and launch it on the bus
          if (start) begin
            state    <= BUSY;
            busy_cnt <= '0;
            dreq     <= 1'b1;
            dwe      <= ~mem_read;
            dbe      <= be_p0;
            daddr    <= {addr[31:2], 2'b00};
            dwdata   <= wd_p0;
            load_p1  <= mem_read;
            size_p1  <= mem_size;
            sign_p1  <= mem_sign;
            off_p1   <= off_p0;
          end
        end
        BUSY: begin
          // p1 -> p2: complete on ack, or give up once the wait budget is spent
          if (dack) begin
            if (load_p1) begin
              load_data <= fmt_load(drdata, size_p1, sign_p1, off_p1);
            end
            dreq  <= 1'b0;
            dwe   <= 1'b0;
            state <= DONE;
          end else if (busy_cnt == TO_LAST) begin
            bus_err <= 1'b1;
            dreq    <= 1'b0;
            dwe     <= 1'b0;
            state   <= DONE;
          end else begin
            busy_cnt <= busy_cnt + 10'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed vector table plus randomized accesses for mem_access,
// checked against a transaction-level model of the access rules.
module tb_mem_access;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_sign;
  logic [31:0] addr;
  logic [31:0] wdata_in;
  logic        dreq;
  logic        dwe;
  logic [3:0]  dbe;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [31:0] drdata;
  logic        dack;
  logic [31:0] load_data;
  logic        stall;
  logic        adel;
  logic        ades;
  logic        bus_err;

  int errors;
  int checks;
  logic [31:0] last_load;

  typedef struct {
    logic        vld;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    int          exp_stall;
    logic        exp_adel;
    logic        exp_ades;
    logic        exp_dwe;
    logic        exp_berr;
    logic [3:0]  exp_dbe;
    logic [31:0] exp_daddr;
    logic [31:0] exp_dwdata;
    logic [31:0] exp_load;
  } vec_t;

  vec_t tbl[11];

  mem_access #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mem_read(mem_read),
    .mem_write(mem_write), .mem_size(mem_size), .mem_sign(mem_sign),
    .addr(addr), .wdata_in(wdata_in), .dreq(dreq), .dwe(dwe), .dbe(dbe),
    .daddr(daddr), .dwdata(dwdata), .drdata(drdata), .dack(dack),
    .load_data(load_data), .stall(stall), .adel(adel), .ades(ades),
    .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic model_misaligned(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    if (sz == 2'd1) return (a % 2) != 0;
    if (sz >= 2'd2) return (a % 4) != 0;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] model_dbe(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 4'(1 << (a % 4));
    if (sz == 2'd1) return ((a % 4) >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_dwdata(input logic [1:0] sz, input logic [31:0] w);
    if (sz == 2'd0) return (w % 256) * 32'h0101_0101;
    if (sz == 2'd1) return (w % 65536) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sx,
                                             input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    int boff;
    if (sz == 2'd0) begin
      boff = a % 4;
      v = (rd >> (8 * boff)) % 256;
      if (sx && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      boff = ((a % 4) >= 2) ? 2 : 0;
      v = (rd >> (8 * boff)) % 65536;
      if (sx && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // ---------------- one access, driven and checked ----------------
  task automatic do_access(input vec_t v);
    int   busy_len;
    int   stalls;
    logic timed;
    in_valid  = v.vld;
    mem_read  = v.rd;
    mem_write = v.wr;
    mem_size  = v.size;
    mem_sign  = v.sign;
    addr      = v.addr;
    wdata_in  = v.wdata;
    dack      = (v.exp_stall == 0);
    drdata    = ~v.rdata;
    #1;
    stalls = stall ? 1 : 0;
    check("adel", adel, v.exp_adel);
    check("ades", ades, v.exp_ades);
    if (v.exp_stall == 0) begin
      check("stall_idle", stall, 0);
      @(negedge clk);
      check("dreq_idle", dreq, 0);
      check("stall_idle2", stall, 0);
      check("bus_err_idle", bus_err, 0);
      check("load_idle", load_data, v.exp_load);
      in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; dack = 1'b0;
    end else begin
      timed    = !(v.lat >= 1 && v.lat <= TO);
      busy_len = timed ? TO : v.lat;
      for (int k = 1; k <= busy_len; k++) begin
        @(negedge clk);
        if (stall) stalls++;
        check("dreq_busy", dreq, 1);
        check("dwe", dwe, v.exp_dwe);
        check("dbe", dbe, v.exp_dbe);
        check("daddr", daddr, v.exp_daddr);
        check("dwdata", dwdata, v.exp_dwdata);
        check("bus_err_busy", bus_err, 0);
        if (k == v.lat) begin
          dack   = 1'b1;
          drdata = v.rdata;
        end
      end
      @(negedge clk);
      check("stall_cycles", stalls, v.exp_stall);
      check("dreq_done", dreq, 0);
      check("stall_done", stall, 0);
      check("bus_err_done", bus_err, v.exp_berr);
      check("load_done", load_data, v.exp_load);
      in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      dack     = 1'b1;
      drdata   = ~v.rdata;
      @(negedge clk);
      dack = 1'b0;
      check("load_after", load_data, v.exp_load);
      check("bus_err_after", bus_err, 0);
      check("dreq_after", dreq, 0);
    end
    last_load = v.exp_load;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    logic mis;
    logic go;
    logic timed;
    v.vld   = ($urandom_range(0, 7) != 0);
    v.rd    = 1'($urandom_range(0, 1));
    v.wr    = 1'($urandom_range(0, 1));
    v.size  = 2'($urandom_range(0, 3));
    v.sign  = 1'($urandom_range(0, 1));
    v.addr  = $urandom;
    v.wdata = $urandom;
    v.rdata = $urandom;
    v.lat   = $urandom_range(0, 6);
    mis     = model_misaligned(v.size, v.addr);
    go      = v.vld && (v.rd || v.wr) && !mis;
    timed   = !(v.lat >= 1 && v.lat <= TO);
    v.exp_adel   = v.vld && v.rd && mis;
    v.exp_ades   = v.vld && !v.rd && v.wr && mis;
    v.exp_stall  = go ? (1 + (timed ? TO : v.lat)) : 0;
    v.exp_dwe    = !v.rd;
    v.exp_berr   = timed;
    v.exp_dbe    = model_dbe(v.size, v.addr);
    v.exp_daddr  = v.addr - (v.addr % 4);
    v.exp_dwdata = model_dwdata(v.size, v.wdata);
    v.exp_load   = (go && v.rd && !timed) ? model_load(v.size, v.sign, v.addr, v.rdata)
                                           : last_load;
    return v;
  endfunction

  initial begin
    errors = 0; checks = 0; last_load = 32'h0;
    rst = 1'b1; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    mem_size = 2'b00; mem_sign = 1'b0; addr = 32'h0; wdata_in = 32'h0;
    drdata = 32'h0; dack = 1'b0;

    //          vld   rd    wr    size   sign  addr          wdata         rdata        lat stl adel  ades  dwe   berr  dbe    daddr         dwdata        load
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 3, 4, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'h0,        32'hDEADBEEF};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,        32'h80FF_0000, 1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 4'h8, 32'h0000_0100, 32'h0,        32'hFFFF_FF80};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,        32'h80FF_0000, 2, 3, 1'b0, 1'b0, 1'b0, 1'b0, 4'h8, 32'h0000_0100, 32'h0,        32'h0000_0080};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'h0,        1, 2, 1'b0, 1'b0, 1'b1, 1'b0, 4'hC, 32'h0000_0200, 32'hABCD_ABCD, 32'h0000_0080};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0105, 32'hFFFF_FFA5, 32'h0,        4, 5, 1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 32'h0000_0104, 32'hA5A5_A5A5, 32'h0000_0080};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 32'h0000_0106, 32'h0,        32'h8001_7FFF, 2, 3, 1'b0, 1'b0, 1'b0, 1'b0, 4'hC, 32'h0000_0104, 32'h0,        32'hFFFF_8001};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_0108, 32'hCAFE_F00D, 32'h0,        3, 4, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0108, 32'hCAFE_F00D, 32'hFFFF_8001};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0,        32'h1357_9BDF, 0, 5, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 32'h0000_0300, 32'h0,        32'hFFFF_8001};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0,        32'h0,        1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 32'h0,        32'h0,        32'hFFFF_8001};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0,        32'h0,        1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 32'h0,        32'h0,        32'hFFFF_8001};
`ifdef MEM_ALIGN_CHECK_EN
    tbl[10] = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0,        32'h1122_3344, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'h0,        32'hFFFF_8001};
`else
    tbl[10] = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0,        32'h1122_3344, 1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'h0,        32'h1122_3344};
`endif

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_dreq", dreq, 0);
    check("rst_dwe", dwe, 0);
    check("rst_dbe", dbe, 0);
    check("rst_daddr", daddr, 0);
    check("rst_dwdata", dwdata, 0);
    check("rst_load", load_data, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_stall", stall, 0);
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 11; i++) do_access(tbl[i]);

    // Reset in the middle of a BUSY wait abandons the access
    in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'b10;
    addr = 32'h0000_0500; dack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_dreq_before", dreq, 1);
    in_valid = 1'b0; mem_read = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_dreq", dreq, 0);
    check("midrst_stall", stall, 0);
    check("midrst_daddr", daddr, 0);
    check("midrst_dbe", dbe, 0);
    check("midrst_load", load_data, 0);
    @(negedge clk);
    check("midrst_dreq_hold", dreq, 0);
    rst = 1'b0;
    last_load = 32'h0;
    do_access('{1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_020C, 32'h0BAD_F00D, 32'h0, 2, 3,
                1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_020C, 32'h0BAD_F00D, 32'h0});

    // Randomized accesses against the model
    for (int i = 0; i < 60; i++) do_access(rand_vec());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum BUSY cycles waiting for dack before a bus error is flagged (legal range 1..1023).
REQ-002 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  MEM-stage instruction present.
REQ-005 SHALL have port mem_read  input  1  load request from mem_ctrl.
REQ-006 SHALL have port mem_write  input  1  store request from mem_ctrl.
REQ-007 SHALL have port mem_size  input  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-008 SHALL have port mem_sign  input  1  1 = sign-extend load (LB/LH), 0 = zero-extend (LBU/LHU).
REQ-009 SHALL have port addr  input  32  effective byte address.
REQ-010 SHALL have port wdata_in  input  32  store data, right-aligned.
REQ-011 SHALL have ports dreq output 1, dwe output 1, dbe output 4, daddr output 32, dwdata output 32: data-bus request, write enable, byte enables, word address (bits[1:0]=0), lane-placed write data.
REQ-012 SHALL have ports drdata input 32 and dack input 1: read data and one-cycle completion strobe.
REQ-013 SHALL have ports load_data output 32 (formatted load result), stall output 1 (hold pipeline), adel output 1 and ades output 1 (load/store address error), bus_err output 1 (timeout).

Function
REQ-014 SHALL implement FSM IDLE, BUSY, DONE; start = in_valid & (mem_read | mem_write) & no address error; mem_read takes priority if both are set.
REQ-015 SHALL, in IDLE on start, register address, size, sign, direction and lane data, move to BUSY, and drive dreq=1 from the next cycle.
REQ-016 SHALL hold dreq, dwe, dbe, daddr and dwdata stable throughout BUSY, and drop dreq on the cycle after dack is sampled.
REQ-017 SHALL, in BUSY on dack, register formatted drdata into load_data (loads only) and move to DONE.
REQ-018 SHALL move from DONE to IDLE unconditionally after one cycle.
REQ-019 SHALL drive stall = (IDLE & start) | BUSY combinationally, and deassert stall in DONE so the pipeline advances exactly once per access.
REQ-020 SHALL count BUSY cycles; when the count reaches TIMEOUT_CYCLES without dack, SHALL pulse bus_err for one cycle, drop dreq, leave load_data unchanged and enter DONE.
REQ-021 SHALL form byte enables little-endian: byte = 1<<addr[1:0]; half = 0011 if addr[1]=0, else 1100; word = 1111.
REQ-022 SHALL place store data by replicating wdata_in[7:0] on all four lanes (byte) or wdata_in[15:0] on both halves (half).
REQ-023 SHALL select load bytes by registered addr[1:0] and extend to 32 bits per mem_sign; word loads pass through.
REQ-024 SHALL ignore dack outside BUSY.
REQ-025 SHALL produce no bus traffic when in_valid=0 or neither mem_read nor mem_write is set; stall then stays 0.

Reset
REQ-026 SHALL, on rst, immediately force state=IDLE, dreq=0, dwe=0, dbe=0, daddr=0, dwdata=0, load_data=0, bus_err=0 and the timeout counter to 0, abandoning any access in flight.
REQ-027 SHALL accept a new access on the first clock edge after rst deasserts.

Configuration
REQ-028 SHALL, with MEM_ALIGN_CHECK_EN defined, treat a half access with addr[0]=1 or a word access with addr[1:0]!=0 as an address error: adel (load) or ades (store) asserted combinationally while in_valid, no bus access, stall=0.
REQ-029 SHALL, without MEM_ALIGN_CHECK_EN, tie adel and ades to 0 and force low address bits aligned (half ignores addr[0], word ignores addr[1:0]).

Verification
REQ-030 SHALL be verified by: LW addr=0x100, dack 3 cycles after dreq with drdata=0xDEADBEEF -> daddr=0x100, dbe=1111, stall for 4 cycles, load_data=0xDEADBEEF.
REQ-031 SHALL be verified by: LB addr=0x103, drdata=0x80FF_0000 -> load_data=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-032 SHALL be verified by: SH addr=0x202, wdata_in=0x1234ABCD -> dwe=1, dbe=1100, dwdata=0xABCDABCD, daddr=0x200.
REQ-033 SHALL be verified by: LW with no dack and TIMEOUT_CYCLES=4 -> dreq high for 4 cycles, then a one-cycle bus_err pulse, stall released, load_data unchanged.
REQ-034 SHALL be verified by: LW addr=0x102 with MEM_ALIGN_CHECK_EN -> adel=1, dreq=0, stall=0; without the macro -> daddr=0x100, normal access.
REQ-035 SHALL be verified by: rst asserted mid-BUSY -> dreq=0 and state IDLE asynchronously; a following SW completes normally.
